// File: rtl/riscv_core_mul_final_adder.sv
// rtl/riscv_core_mul_final_adder.sv - two-stage carry-propagate adder closing the multiplier datapath
// Low half added in stage 1, high half plus carry in stage 2, then low/high/word select.
module riscv_core_mul_final_adder #(
   parameter int XLEN  = 64,
   parameter int TAG_W = 5
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_mul_final_adder_valid,
   output logic                o_mul_final_adder_ready,
   input  logic [2*XLEN-1:0]   i_mul_final_adder_sum,
   input  logic [2*XLEN-1:0]   i_mul_final_adder_carry,
   input  logic                i_mul_final_adder_high,
   input  logic                i_mul_final_adder_word,
   input  logic [TAG_W-1:0]    i_mul_final_adder_tag,
   output logic                o_mul_final_adder_valid,
   input  logic                i_mul_final_adder_ready,
   output logic [XLEN-1:0]     o_mul_final_adder_result,
   output logic [TAG_W-1:0]    o_mul_final_adder_tag
);

   logic              s1_vld;
   logic [XLEN-1:0]   s1_lo;
   logic              s1_c1;
   logic [XLEN-1:0]   s1_sum_hi;
   logic [XLEN-1:0]   s1_carry_hi;
   logic              s1_high;
   logic              s1_word;
   logic [TAG_W-1:0]  s1_tag;

   logic              s2_free;
   logic              advance;
   logic              accept;
   logic [XLEN:0]     lo_sum;
   logic [XLEN-1:0]   hi_sum;
   logic [XLEN-1:0]   word_res;
   logic [XLEN-1:0]   sel_res;

   assign s2_free                 = !o_mul_final_adder_valid || i_mul_final_adder_ready;
   assign advance                 = s1_vld && s2_free;
   assign o_mul_final_adder_ready = !s1_vld || s2_free;
   assign accept                  = i_mul_final_adder_valid && o_mul_final_adder_ready;

   assign lo_sum   = {1'b0, i_mul_final_adder_sum[XLEN-1:0]} + {1'b0, i_mul_final_adder_carry[XLEN-1:0]};
   // Final carry-out of the high half is dropped: product is modulo 2^(2*XLEN).
   assign hi_sum   = s1_sum_hi + s1_carry_hi + {{(XLEN-1){1'b0}}, s1_c1};
   assign word_res = {{(XLEN-32){s1_lo[31]}}, s1_lo[31:0]};

   always_comb begin
      sel_res = s1_lo;
      if (s1_word)
         sel_res = word_res;
      else if (s1_high)
         sel_res = hi_sum;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_vld      <= 1'b0;
         s1_lo       <= '0;
         s1_c1       <= 1'b0;
         s1_sum_hi   <= '0;
         s1_carry_hi <= '0;
         s1_high     <= 1'b0;
         s1_word     <= 1'b0;
         s1_tag      <= '0;
      end else if (accept) begin
         s1_vld      <= 1'b1;
         s1_lo       <= lo_sum[XLEN-1:0];
         s1_c1       <= lo_sum[XLEN];
         s1_sum_hi   <= i_mul_final_adder_sum[2*XLEN-1:XLEN];
         s1_carry_hi <= i_mul_final_adder_carry[2*XLEN-1:XLEN];
         s1_high     <= i_mul_final_adder_high;
         s1_word     <= i_mul_final_adder_word;
         s1_tag      <= i_mul_final_adder_tag;
      end else if (advance) begin
         s1_vld      <= 1'b0;
      end
   end

   // Output register reloads on advance even while a transfer drains it in the same cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_mul_final_adder_valid  <= 1'b0;
         o_mul_final_adder_result <= '0;
         o_mul_final_adder_tag    <= '0;
      end else if (advance) begin
         o_mul_final_adder_valid  <= 1'b1;
         o_mul_final_adder_result <= sel_res;
         o_mul_final_adder_tag    <= s1_tag;
      end else if (i_mul_final_adder_ready) begin
         o_mul_final_adder_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_riscv_core_mul_final_adder.sv
// tb/tb_riscv_core_mul_final_adder.sv - self-checking bench for riscv_core_mul_final_adder
module tb_riscv_core_mul_final_adder;

   localparam int XLEN  = 64;
   localparam int TAG_W = 5;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [127:0]      in_sum;
   logic [127:0]      in_carry;
   logic              in_high;
   logic              in_word;
   logic [TAG_W-1:0]  in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_result;
   logic [TAG_W-1:0]  out_tag;

   riscv_core_mul_final_adder #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .i_clk                    (clk),
      .i_rst                    (rst),
      .i_mul_final_adder_valid  (in_valid),
      .o_mul_final_adder_ready  (in_ready),
      .i_mul_final_adder_sum    (in_sum),
      .i_mul_final_adder_carry  (in_carry),
      .i_mul_final_adder_high   (in_high),
      .i_mul_final_adder_word   (in_word),
      .i_mul_final_adder_tag    (in_tag),
      .o_mul_final_adder_valid  (out_valid),
      .i_mul_final_adder_ready  (out_ready),
      .o_mul_final_adder_result (out_result),
      .o_mul_final_adder_tag    (out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [XLEN-1:0]  res;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t             exp_q[$];
   int               passed = 0;
   int               total  = 0;
   bit               held   = 0;
   logic [XLEN-1:0]  held_res;
   logic [TAG_W-1:0] held_tag;
   int               run     = 0;
   int               max_run = 0;
   int               vcount  = 0;

   // Full product as a plain 128-bit sum, then pick the architectural view of it.
   function automatic logic [XLEN-1:0] ref_res(input logic [127:0] s, input logic [127:0] c,
                                               input logic h, input logic w);
      logic [127:0] p;
      p = s + c;
      if (w)      return {{32{p[31]}}, p[31:0]};
      else if (h) return p[127:64];
      else        return p[63:0];
   endfunction

   task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
   endtask

   // One clock: called at a negedge with inputs already driven; returns at the next negedge.
   task automatic cycle();
      exp_t e;
      #1;
      if (held) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_result", out_result, held_res);
         chk("hold_tag", out_tag, held_tag);
      end
      held     = out_valid && !out_ready;
      held_res = out_result;
      held_tag = out_tag;
      if (out_valid) begin
         vcount++;
         run++;
         if (run > max_run) max_run = run;
      end else begin
         run = 0;
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("sb_result", out_result, e.res);
            chk("sb_tag", out_tag, e.tag);
         end
      end
      if (in_valid && in_ready) begin
         e.res = ref_res(in_sum, in_carry, in_high, in_word);
         e.tag = in_tag;
         exp_q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic [127:0] s, input logic [127:0] c, input logic h,
                        input logic w, input logic [TAG_W-1:0] t);
      in_valid = 1'b1;
      in_sum   = s;
      in_carry = c;
      in_high  = h;
      in_word  = w;
      in_tag   = t;
   endtask

   task automatic directed(input string name, input logic [127:0] s, input logic [127:0] c,
                           input logic h, input logic w, input logic [TAG_W-1:0] t,
                           input logic [XLEN-1:0] exp);
      out_ready = 1'b1;
      drive(s, c, h, w, t);
      cycle();
      in_valid = 1'b0;
      chk({name, "_lat_early"}, out_valid, 0);
      cycle();
      chk({name, "_lat_valid"}, out_valid, 1);
      chk({name, "_result"}, out_result, exp);
      chk({name, "_tag"}, out_tag, t);
      cycle();
   endtask

   task automatic drain();
      out_ready = 1'b1;
      in_valid  = 1'b0;
      for (int k = 0; k < 50 && (exp_q.size() != 0 || out_valid); k++) cycle();
      chk("drain_complete", (exp_q.size() == 0) && !out_valid, 1);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_sum = '0;
      in_carry = '0;
      in_high = 1'b0;
      in_word = 1'b0;
      in_tag = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_result", out_result, 0);
      chk("rst_tag", out_tag, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", in_ready, 1);

      directed("basic", 128'd3, 128'd5, 1'b0, 1'b0, 5'd7, 64'h8);
      directed("xcarry_hi", {64'h2, 64'hFFFF_FFFF_FFFF_FFFF}, {64'h3, 64'h1}, 1'b1, 1'b0, 5'd9, 64'h6);
      directed("xcarry_lo", {64'h2, 64'hFFFF_FFFF_FFFF_FFFF}, {64'h3, 64'h1}, 1'b0, 1'b0, 5'd10, 64'h0);
      directed("word_neg", 128'h7FFF_FFFF, 128'h1, 1'b1, 1'b1, 5'd11, 64'hFFFF_FFFF_8000_0000);
      directed("word_trunc", 128'h1_0000_0005, 128'h0, 1'b0, 1'b1, 5'd12, 64'h5);

      // Back-to-back throughput
      vcount = 0; run = 0; max_run = 0;
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         drive({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
               1'($urandom_range(0, 1)), 1'b0, 5'(i));
         chk("b2b_ready", in_ready, 1);
         cycle();
      end
      drain();
      chk("b2b_count", vcount, 4);
      chk("b2b_consecutive", max_run, 4);

      // Backpressure
      out_ready = 1'b0;
      drive(128'd100, 128'd1, 1'b0, 1'b0, 5'd21);
      chk("bp_ready_1", in_ready, 1);
      cycle();
      drive(128'd200, 128'd2, 1'b0, 1'b0, 5'd22);
      chk("bp_ready_2", in_ready, 1);
      cycle();
      drive(128'd300, 128'd3, 1'b0, 1'b0, 5'd23);
      chk("bp_ready_full", in_ready, 0);
      cycle();
      chk("bp_ready_still", in_ready, 0);
      chk("bp_held_result", out_result, 64'd101);
      cycle();
      out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      drain();

      // Reset mid-flight
      out_ready = 1'b0;
      drive(128'd5, 128'd6, 1'b0, 1'b0, 5'd1);
      cycle();
      drive(128'd7, 128'd8, 1'b0, 1'b0, 5'd2);
      cycle();
      in_valid = 1'b0;
      chk("mid_inflight", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("async_valid", out_valid, 0);
      chk("async_result", out_result, 0);
      chk("async_tag", out_tag, 0);
      exp_q.delete();
      held = 0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", in_ready, 1);
      chk("post_rst_valid", out_valid, 0);
      directed("post_rst", 128'd40, 128'd2, 1'b0, 1'b0, 5'd30, 64'd42);

      // Randomized traffic with random backpressure
      for (int i = 0; i < 300; i++) begin
         logic [127:0] s, c;
         s = {$urandom, $urandom, $urandom, $urandom};
         c = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 3) == 0) c[63:0] = ~s[63:0] + 64'($urandom_range(0, 2));
         drive(s, c, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 5'($urandom));
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         cycle();
      end
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/riscv_core_mul_final_adder.md
Name: riscv_core_mul_final_adder

Overview:
Final carry-propagate stage of the multiplier datapath, directly downstream of the 4:2 compressor tree. It takes the redundant sum/carry vectors (2*XLEN bits each) produced by the tree and adds them in a 2-stage pipeline: low half in stage 1, high half plus registered carry in stage 2. It then selects the low/high product half or the W-form result and hands it to writeback with a valid/ready handshake. Signedness correction is done upstream; this block treats the vectors as unsigned modulo 2^(2*XLEN).

Parameters:
XLEN, 64, datapath width; the product vectors are 2*XLEN wide.
TAG_W, 5, width of the pass-through tag (destination register index).

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous, active-high reset
i_mul_final_adder_valid  input  1  input vectors valid
o_mul_final_adder_ready  output  1  block can accept input this cycle
i_mul_final_adder_sum  input  2*XLEN  compressor-tree sum vector
i_mul_final_adder_carry  input  2*XLEN  compressor-tree carry vector (already aligned)
i_mul_final_adder_high  input  1  1 = return product[2*XLEN-1:XLEN] (MULH/MULHSU/MULHU)
i_mul_final_adder_word  input  1  1 = MULW: return sign-extended product[31:0]; overrides high
i_mul_final_adder_tag  input  TAG_W  opaque tag, returned with the result
o_mul_final_adder_valid  output  1  result valid
i_mul_final_adder_ready  input  1  consumer accepts the result
o_mul_final_adder_result  output  XLEN  selected result
o_mul_final_adder_tag  output  TAG_W  tag of the result

Behaviour:
- Input accept: valid && o_ready at a rising edge. Output transfer: o_valid && i_ready.
- Stage 1, on accept:
  - register lo = sum[XLEN-1:0] + carry[XLEN-1:0] and the carry-out c1;
  - register sum[2XLEN-1:XLEN], carry[2XLEN-1:XLEN], high, word, tag;
  - set s1_vld.
- Stage 2, on advance: hi = sum_hi + carry_hi + c1, truncated to XLEN; the final carry-out is discarded. Result select:
  - word=1: {32{lo[31]}, lo[31:0]};
  - else high=1: hi;
  - else: lo.
  - The selected result and tag go into the output register, and o_valid is set.
- Stall logic:
  - s2_free = !o_valid || i_ready;
  - stage 1 advances when s1_vld && s2_free;
  - o_ready = !s1_vld || s2_free (combinational; no dependency on i_valid).
- Latency: exactly 2 cycles from accept to o_valid with no backpressure. Throughput is 1 result per cycle.
- Backpressure: while o_valid && !i_ready, o_result and o_tag hold stable. At most 2 operations in flight (s1 + output register). When both are full, o_ready = 0.
- Simultaneous output transfer and stage-1 advance in one cycle: the output register is reloaded and o_valid stays 1. An empty stage 1 with a transfer clears o_valid.
- Simultaneous accept and stage-1 advance: stage 1 is overwritten with the new operation.
- Order is strictly FIFO. No operation is dropped or duplicated.
- Reset (asynchronous, any time, including mid-operation):
  - o_valid = 0, o_result = 0, o_tag = 0, s1_vld = 0, all stage-1 registers = 0;
  - in-flight operations are discarded;
  - o_ready = 1 from the first cycle after reset deasserts.
- Datapath registers other than valids may skip reset only if o_result/o_tag still read 0 out of reset. Required: reset all.

Test Plan:
1. Basic: sum=3, carry=5, high=0, word=0, tag=7, i_ready=1 -> o_valid 2 cycles later, result=0x8, tag=7.
2. Cross-half carry: sum lo=0xFFFF_FFFF_FFFF_FFFF, carry lo=1, sum hi=0x2, carry hi=0x3, high=1 -> result=0x6; same operands with high=0 -> result=0.
3. Word form: sum=0x7FFF_FFFF, carry=1, word=1, high=1 -> result=0xFFFF_FFFF_8000_0000. Sum=0x1_0000_0005, carry=0, word=1 -> result=0x5.
4. Back-to-back throughput: 4 ops on consecutive cycles, tags 1..4, i_ready=1 -> o_valid high 4 consecutive cycles, results/tags in order, o_ready never drops.
5. Backpressure: i_ready=0, issue 3 ops -> o_ready drops after the 2nd accept, the 3rd is held upstream, o_result is stable. Release i_ready -> all 3 delivered in order with no loss or duplication.
6. Reset mid-flight: assert i_rst with 2 ops in flight -> o_valid=0, o_result=0, o_tag=0 immediately (asynchronous). After release, o_ready=1 and a new op completes with the correct value in 2 cycles.
